// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game controller.
// Direction codes, FSM state codes, LFSR seed/taps and field defaults.
package snake_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_PLACE   = 3'd2,
    ST_OVER    = 3'd3,
    ST_RESTART = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int H_CELLS_DEF = 40;
  localparam int V_CELLS_DEF = 30;

  function automatic logic is_reverse(
    input logic [1:0] cur,
    input logic [1:0] nd
  );
    return (cur[1] == nd[1]) && (cur[0] != nd[0]);
  endfunction

endpackage

// File: rtl/snake_fruit_placer.sv
// Free-running LFSR fruit placer with a bounded draw/reject loop.
// req starts a search; done pulses with the chosen fruit cell.
module snake_fruit_placer
  import snake_pkg::*;
#(
  parameter int H_CELLS   = H_CELLS_DEF,
  parameter int V_CELLS   = V_CELLS_DEF,
  parameter int PLACE_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       abort,
  input  logic [5:0] head_x,
  input  logic [5:0] head_y,
  input  logic [5:0] cur_x,
  input  logic [5:0] cur_y,
  output logic       done,
  output logic [5:0] fruit_x,
  output logic [5:0] fruit_y
);

  localparam int CW = $clog2(PLACE_MAX + 1);
  localparam logic [6:0] HW = 7'(H_CELLS);
  localparam logic [6:0] VW = 7'(V_CELLS);
  localparam logic [6:0] HHALF = 7'(H_CELLS / 2);

  logic [15:0]   lfsr;
  logic          busy;
  logic [CW-1:0] tries;
  logic [5:0]    cx;
  logic [5:0]    cy;
  logic          ok;
  logic          give_up;
  logic [6:0]    fb_x;

  assign cx = lfsr[5:0];
  assign cy = lfsr[11:6];

  assign ok = ({1'b0, cx} < HW)
           && ({1'b0, cy} < VW)
           && !(cx == head_x && cy == head_y)
           && !(cx == cur_x && cy == cur_y);

  assign give_up = (tries == CW'(PLACE_MAX));
  assign fb_x = ({1'b0, head_x} + HHALF) % HW;

  always_comb begin
    done    = 1'b0;
    fruit_x = cx;
    fruit_y = cy;
    if (busy) begin
      if (ok) begin
        done = 1'b1;
      end else if (give_up) begin
        done    = 1'b1;
        fruit_x = fb_x[5:0];
        fruit_y = head_y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr  <= LFSR_SEED;
      busy  <= 1'b0;
      tries <= '0;
    end else begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      if (req) begin
        busy  <= 1'b1;
        tries <= '0;
      end else if (abort || done) begin
        busy <= 1'b0;
      end else if (busy) begin
        tries <= tries + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Game sequencer: step tick with speed-up, direction filter,
// fruit placement and the idle/play/place/over/restart FSM.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int H_CELLS   = H_CELLS_DEF,
  parameter int V_CELLS   = V_CELLS_DEF,
  parameter int TICK_INIT = 12_500_000,
  parameter int TICK_DEC  = 500_000,
  parameter int TICK_MIN  = 2_500_000,
  parameter int FRUIT_X0  = 21,
  parameter int FRUIT_Y0  = 15,
  parameter int PLACE_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [5:0] head_x,
  input  logic [5:0] head_y,
  input  logic       ate_fruit,
  input  logic       game_over,
  output logic       engine_rst_n,
  output logic       step,
  output logic [1:0] dir,
  output logic [5:0] fruit_x_cell,
  output logic [5:0] fruit_y_cell,
  output logic [7:0] score,
  output logic [2:0] state
);

  localparam logic [23:0] P_INIT = 24'(TICK_INIT);
  localparam logic [23:0] P_DEC  = 24'(TICK_DEC);
  localparam logic [23:0] P_MIN  = 24'(TICK_MIN);
  localparam logic [24:0] P_KNEE = {1'b0, P_MIN} + {1'b0, P_DEC};

  state_t      cur;
  state_t      nxt;
  logic [23:0] period;
  logic [23:0] cnt;
  logic [1:0]  pend;
  logic        ate_d;
  logic        ate_rise;
  logic        tick;
  logic        place_req;
  logic        place_abort;
  logic        place_done;
  logic [5:0]  place_x;
  logic [5:0]  place_y;
  logic        btn_any;
  logic [1:0]  btn_dir;

  assign state    = cur;
  assign ate_rise = ate_fruit & ~ate_d;
  // >= keeps the tick safe when period shrinks below a frozen count.
  assign tick     = (cnt >= period - 24'd1);

  assign place_req   = (cur == ST_PLAY) && (nxt == ST_PLACE);
  assign place_abort = (cur == ST_PLACE) && game_over;

  always_comb begin
    btn_any = 1'b1;
    btn_dir = DIR_RIGHT;
    if (btn_up)         btn_dir = DIR_UP;
    else if (btn_down)  btn_dir = DIR_DOWN;
    else if (btn_left)  btn_dir = DIR_LEFT;
    else if (btn_right) btn_dir = DIR_RIGHT;
    else                btn_any = 1'b0;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      ST_IDLE:    if (start) nxt = ST_PLAY;
      ST_PLAY: begin
        if (game_over)     nxt = ST_OVER;
        else if (ate_rise) nxt = ST_PLACE;
      end
      ST_PLACE: begin
        if (game_over)       nxt = ST_OVER;
        else if (place_done) nxt = ST_PLAY;
      end
      ST_OVER:    if (start) nxt = ST_RESTART;
      ST_RESTART: nxt = ST_PLAY;
      default:    nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur          <= ST_IDLE;
      engine_rst_n <= 1'b0;
      step         <= 1'b0;
      dir          <= DIR_RIGHT;
      pend         <= DIR_RIGHT;
      fruit_x_cell <= 6'(FRUIT_X0);
      fruit_y_cell <= 6'(FRUIT_Y0);
      score        <= 8'd0;
      period       <= P_INIT;
      cnt          <= 24'd0;
      ate_d        <= 1'b0;
    end else begin
      cur          <= nxt;
      ate_d        <= ate_fruit;
      engine_rst_n <= (nxt == ST_PLAY)
                   || (nxt == ST_PLACE)
                   || (nxt == ST_OVER);
      step <= 1'b0;
      if ((cur == ST_PLAY || cur == ST_PLACE)
          && btn_any && !is_reverse(dir, btn_dir))
        pend <= btn_dir;
      if (cur == ST_PLAY && nxt == ST_PLAY) begin
        if (tick) begin
          step <= 1'b1;
          cnt  <= 24'd0;
          dir  <= pend;
        end else begin
          cnt <= cnt + 24'd1;
        end
      end
      if (place_req) begin
        if (score != 8'hFF) score <= score + 8'd1;
        if ({1'b0, period} > P_KNEE) period <= period - P_DEC;
        else                         period <= P_MIN;
      end
      if (cur == ST_PLACE && place_done && !game_over) begin
        fruit_x_cell <= place_x;
        fruit_y_cell <= place_y;
      end
      if (cur == ST_RESTART) begin
        dir          <= DIR_RIGHT;
        pend         <= DIR_RIGHT;
        fruit_x_cell <= 6'(FRUIT_X0);
        fruit_y_cell <= 6'(FRUIT_Y0);
        score        <= 8'd0;
        period       <= P_INIT;
        cnt          <= 24'd0;
      end
    end
  end

  snake_fruit_placer #(
    .H_CELLS  (H_CELLS),
    .V_CELLS  (V_CELLS),
    .PLACE_MAX(PLACE_MAX)
  ) u_placer (
    .clk    (clk),
    .rst    (rst),
    .req    (place_req),
    .abort  (place_abort),
    .head_x (head_x),
    .head_y (head_y),
    .cur_x  (fruit_x_cell),
    .cur_y  (fruit_y_cell),
    .done   (place_done),
    .fruit_x(place_x),
    .fruit_y(place_y)
  );

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl: tick, direction filter,
// placement, fallback, game over/restart and speed/score limits.
module tb_snake_game_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic [5:0] head_x;
  logic [5:0] head_y;
  logic       ate_fruit;
  logic       game_over;
  logic       engine_rst_n;
  logic       step;
  logic [1:0] dir;
  logic [5:0] fruit_x_cell;
  logic [5:0] fruit_y_cell;
  logic [7:0] score;
  logic [2:0] state;

  logic       s_start;
  logic       s_ate;
  logic       s_erst;
  logic       s_step;
  logic [1:0] s_dir;
  logic [5:0] s_fx;
  logic [5:0] s_fy;
  logic [7:0] s_score;
  logic [2:0] s_state;

  int checks;
  int failures;

  snake_game_ctrl #(
    .TICK_INIT(10),
    .TICK_DEC (1),
    .TICK_MIN (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .head_x      (head_x),
    .head_y      (head_y),
    .ate_fruit   (ate_fruit),
    .game_over   (game_over),
    .engine_rst_n(engine_rst_n),
    .step        (step),
    .dir         (dir),
    .fruit_x_cell(fruit_x_cell),
    .fruit_y_cell(fruit_y_cell),
    .score       (score),
    .state       (state)
  );

  snake_game_ctrl #(
    .H_CELLS  (1),
    .V_CELLS  (1),
    .TICK_INIT(10),
    .TICK_DEC (1),
    .TICK_MIN (5)
  ) u_small (
    .clk         (clk),
    .rst         (rst),
    .start       (s_start),
    .btn_up      (1'b0),
    .btn_down    (1'b0),
    .btn_left    (1'b0),
    .btn_right   (1'b0),
    .head_x      (6'd0),
    .head_y      (6'd0),
    .ate_fruit   (s_ate),
    .game_over   (1'b0),
    .engine_rst_n(s_erst),
    .step        (s_step),
    .dir         (s_dir),
    .fruit_x_cell(s_fx),
    .fruit_y_cell(s_fy),
    .score       (s_score),
    .state       (s_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_step(input int max);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step && n < max);
    if (!step) chk("step_timeout", 0, 1);
  endtask

  task automatic gap(input string tag, input int exp);
    int n;
    wait_step(60);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step && n < 60);
    chk(tag, n, exp);
  endtask

  task automatic wait_play(input int max);
    int n;
    n = 0;
    while (state != 3'd1 && n < max) begin
      cyc();
      n++;
    end
    if (state != 3'd1) chk("play_timeout", state, 1);
  endtask

  task automatic eat();
    ate_fruit = 1'b1;
    cyc();
    ate_fruit = 1'b0;
    wait_play(400);
  endtask

  task automatic press(input int b);
    btn_up    = (b == 0);
    btn_down  = (b == 1);
    btn_left  = (b == 2);
    btn_right = (b == 3);
    cyc();
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
  endtask

  initial begin
    int n;
    logic place_step;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    head_x    = 6'd21;
    head_y    = 6'd15;
    ate_fruit = 1'b0;
    game_over = 1'b0;
    s_start   = 1'b0;
    s_ate     = 1'b0;
    repeat (3) cyc();
    chk("rst_state", state, 0);
    chk("rst_erst", engine_rst_n, 0);
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_fx", fruit_x_cell, 21);
    chk("rst_fy", fruit_y_cell, 15);
    chk("rst_score", score, 0);
    rst = 1'b0;
    cyc();
    chk("idle_hold", state, 0);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("play_state", state, 1);
    chk("play_erst", engine_rst_n, 1);
    for (int k = 1; k <= 30; k++) begin
      cyc();
      chk($sformatf("step_k%0d", k), step, (k % 10 == 0) ? 1 : 0);
    end
    chk("dir_init", dir, 0);

    press(2);
    wait_step(60);
    chk("rev_reject", dir, 0);
    press(0);
    press(2);
    wait_step(60);
    chk("up_then_left", dir, 2);
    press(1);
    press(2);
    wait_step(60);
    chk("down_rej_left", dir, 1);
    btn_up   = 1'b1;
    btn_down = 1'b1;
    cyc();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    wait_step(60);
    chk("prio_up", dir, 2);

    place_step = 1'b0;
    ate_fruit  = 1'b1;
    cyc();
    chk("place_state", state, 2);
    chk("score_1", score, 1);
    n = 0;
    while (state != 3'd1 && n < 400) begin
      if (n == 1) ate_fruit = 1'b0;
      if (state == 3'd2 && step) place_step = 1'b1;
      cyc();
      n++;
    end
    ate_fruit = 1'b0;
    chk("place_done", state, 1);
    chk("place_nostep", place_step, 0);
    repeat (4) cyc();
    chk("score_held", score, 1);
    chk("fx_range", fruit_x_cell < 40, 1);
    chk("fy_range", fruit_y_cell < 30, 1);
    chk("fruit_moved",
        (fruit_x_cell == 21 && fruit_y_cell == 15), 0);
    gap("gap_9", 9);

    game_over = 1'b1;
    ate_fruit = 1'b1;
    cyc();
    ate_fruit = 1'b0;
    chk("over_state", state, 3);
    chk("over_score", score, 1);
    chk("over_step", step, 0);
    place_step = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cyc();
      if (step || state != 3'd3) place_step = 1'b1;
    end
    chk("over_hold", place_step, 0);
    chk("over_erst", engine_rst_n, 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_state", state, 4);
    chk("restart_erst", engine_rst_n, 0);
    game_over = 1'b0;
    cyc();
    chk("rs_state", state, 1);
    chk("rs_erst", engine_rst_n, 1);
    chk("rs_score", score, 0);
    chk("rs_fx", fruit_x_cell, 21);
    chk("rs_fy", fruit_y_cell, 15);
    chk("rs_dir", dir, 0);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step && n < 60);
    chk("rs_first_step", n, 10);

    repeat (4) eat();
    gap("gap_6", 6);
    eat();
    gap("gap_5", 5);
    eat();
    gap("gap_clamp", 5);
    repeat (249) eat();
    chk("score_255", score, 255);
    eat();
    chk("score_sat", score, 255);

    s_start = 1'b1;
    cyc();
    s_start = 1'b0;
    chk("sm_play", s_state, 1);
    s_ate = 1'b1;
    cyc();
    s_ate = 1'b0;
    chk("sm_place", s_state, 2);
    repeat (200) cyc();
    chk("sm_still_place", s_state, 2);
    n = 0;
    while (s_state != 3'd1 && n < 100) begin
      cyc();
      n++;
    end
    chk("sm_back_play", s_state, 1);
    chk("sm_fx", s_fx, 0);
    chk("sm_fy", s_fy, 0);
    chk("sm_score", s_score, 1);

    #2 rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_score", score, 0);
    chk("arst_erst", engine_rst_n, 0);
    chk("arst_fx", fruit_x_cell, 21);
    chk("arst_small_fx", s_fx, 21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
